// File: rtl/topo_spawner.sv
// Whack-a-mole spawner: picks LFSR cells, strobes them to the board, times each hit window,
// and keeps score/miss counts with a window that tightens as the score grows.
module topo_spawner #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned WINDOW_MIN    = 12_500_000,
    parameter int unsigned WINDOW_STEP   = 6_250_000,
    parameter int unsigned GAP_CYCLES    = 25_000_000,
    parameter int unsigned MAX_MISSES    = 3,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit,
    output logic [3:0]         n_celda_poner_topo,
    output logic               poner_topo,
    output logic               topo_expire,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               busy,
    output logic               game_over
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {StIdle, StGap, StSpawn, StWait, StOver} state_t;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [31:0]        r_cnt;
    logic [31:0]        r_window_len;
    logic [3:0]         r_cell;
    logic [3:0]         r_last_cell;
    logic [2:0]         r_hits_mod8;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_misses;
    logic               r_poner;
    logic               r_expire;
    logic               r_busy;
    logic               r_game_over;

    logic [15:0]        w_lfsr_nxt;
    logic [3:0]         w_cand;
    logic [3:0]         w_cell;
    logic [3:0]         w_misses_nxt;

    always_comb begin
        w_lfsr_nxt   = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_cand       = r_lfsr[3:0];
        w_cell       = (w_cand == r_last_cell) ? w_cand + 4'd1 : w_cand;
        w_misses_nxt = r_misses + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_lfsr       <= SeedEff;
            r_cnt        <= '0;
            r_window_len <= WINDOW_CYCLES;
            r_cell       <= '0;
            r_last_cell  <= '0;
            r_hits_mod8  <= '0;
            r_score      <= '0;
            r_misses     <= '0;
            r_poner      <= 1'b0;
            r_expire     <= 1'b0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_lfsr   <= w_lfsr_nxt;
            r_poner  <= 1'b0;
            r_expire <= 1'b0;
            case (r_state)
                StIdle, StOver: begin
                    if (start) begin
                        r_state      <= StGap;
                        r_cnt        <= '0;
                        r_score      <= '0;
                        r_misses     <= '0;
                        r_window_len <= WINDOW_CYCLES;
                        r_hits_mod8  <= '0;
                        r_busy       <= 1'b1;
                        r_game_over  <= 1'b0;
                    end
                end
                StGap: begin
                    if (r_cnt == GAP_CYCLES - 1) begin
                        r_cell  <= w_cell;
                        r_poner <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StSpawn;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StSpawn: begin
                    r_last_cell <= r_cell;
                    r_cnt       <= '0;
                    r_state     <= StWait;
                end
                StWait: begin
                    // A hit on the final window cycle wins over the timeout.
                    if (hit) begin
                        if (r_score != '1) begin
                            r_score <= r_score + SCORE_W'(1);
                        end
                        r_hits_mod8 <= r_hits_mod8 + 3'd1;
                        if (r_hits_mod8 == 3'd7) begin
                            if (r_window_len >= WINDOW_MIN + WINDOW_STEP) begin
                                r_window_len <= r_window_len - WINDOW_STEP;
                            end else begin
                                r_window_len <= WINDOW_MIN;
                            end
                        end
                        r_cnt   <= '0;
                        r_state <= StGap;
                    end else if (r_cnt == r_window_len - 32'd1) begin
                        r_expire <= 1'b1;
                        r_misses <= w_misses_nxt;
                        r_cnt    <= '0;
                        if (w_misses_nxt == 4'(MAX_MISSES)) begin
                            r_state     <= StOver;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= StGap;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign n_celda_poner_topo = r_cell;
    assign poner_topo         = r_poner;
    assign topo_expire        = r_expire;
    assign score              = r_score;
    assign misses             = r_misses;
    assign busy               = r_busy;
    assign game_over          = r_game_over;

endmodule

// File: tb/tb_topo_spawner.sv
// Directed bench for topo_spawner with small timing parameters and a reference LFSR for cell picks.
module tb_topo_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [3:0] n_celda_poner_topo;
    logic       poner_topo;
    logic       topo_expire;
    logic [7:0] score;
    logic [3:0] misses;
    logic       busy;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_d;
    logic [3:0]  m_last = 4'd0;

    always #5 clk = ~clk;

    topo_spawner #(
        .SEED          (SEED),
        .WINDOW_CYCLES (8),
        .WINDOW_MIN    (4),
        .WINDOW_STEP   (2),
        .GAP_CYCLES    (4),
        .MAX_MISSES    (3),
        .SCORE_W       (8)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .hit                (hit),
        .n_celda_poner_topo (n_celda_poner_topo),
        .poner_topo         (poner_topo),
        .topo_expire        (topo_expire),
        .score              (score),
        .misses             (misses),
        .busy               (busy),
        .game_over          (game_over)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR; m_lfsr_d holds the value seen during the previous cycle.
    always @(posedge clk) begin
        m_lfsr_d <= m_lfsr;
        m_lfsr   <= reset ? SEED : lfsr_next(m_lfsr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cell is picked on the last GAP cycle, so the model uses the previous cycle's LFSR.
    task automatic expect_spawn_in(input int n);
        logic [3:0] cand;
        logic [3:0] want;
        for (int i = 0; i < n - 1; i++) begin
            step();
            check_eq("no_spawn_early", 32'(poner_topo), 32'd0);
        end
        step();
        cand = m_lfsr_d[3:0];
        want = (cand == m_last) ? cand + 4'd1 : cand;
        check_eq("spawn", 32'(poner_topo), 32'd1);
        check_eq("spawn_cell", 32'(n_celda_poner_topo), 32'(want));
        check_eq("no_expire_at_spawn", 32'(topo_expire), 32'd0);
        m_last = want;
    endtask

    task automatic expect_expire_in(input int n, input int misses_want);
        for (int i = 0; i < n - 1; i++) begin
            step();
            check_eq("no_expire_early", 32'(topo_expire), 32'd0);
        end
        step();
        check_eq("expire", 32'(topo_expire), 32'd1);
        check_eq("expire_cell", 32'(n_celda_poner_topo), 32'(m_last));
        check_eq("expire_misses", 32'(misses), 32'(misses_want));
        check_eq("no_spawn_at_expire", 32'(poner_topo), 32'd0);
    endtask

    task automatic hit_after(input int k, input int score_want);
        for (int i = 0; i < k; i++) begin
            step();
        end
        hit = 1'b1;
        step();
        hit = 1'b0;
        check_eq("hit_score", 32'(score), 32'(score_want));
        check_eq("hit_no_expire", 32'(topo_expire), 32'd0);
    endtask

    task automatic hit_stage(input int base, input int win, input int misses_want);
        for (int j = 0; j < 8; j++) begin
            hit_after(1, base + j + 1);
            expect_spawn_in(4);
        end
        expect_expire_in(win + 1, misses_want);
    endtask

    initial begin
        logic [15:0] seen;
        logic [3:0]  prev;

        // Reset values
        step();
        step();
        check_eq("rst_poner", 32'(poner_topo), 32'd0);
        check_eq("rst_expire", 32'(topo_expire), 32'd0);
        check_eq("rst_cell", 32'(n_celda_poner_topo), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_misses", 32'(misses), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        reset = 1'b0;
        step();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Start: busy next cycle, first mole 5 cycles after start
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_over", 32'(game_over), 32'd0);
        expect_spawn_in(4);
        step();
        check_eq("poner_one_cycle", 32'(poner_topo), 32'd0);

        // Hit 3 cycles after spawn (one step already taken above)
        hit_after(2, 1);
        check_eq("hit_misses", 32'(misses), 32'd0);
        expect_spawn_in(4);

        // Hit on the exact timeout cycle, then held through GAP and SPAWN
        for (int i = 0; i < 8; i++) step();
        hit = 1'b1;
        step();
        check_eq("edge_hit_score", 32'(score), 32'd2);
        check_eq("edge_hit_misses", 32'(misses), 32'd0);
        check_eq("edge_hit_no_expire", 32'(topo_expire), 32'd0);
        step();
        check_eq("gap_hit_ignored", 32'(score), 32'd2);
        expect_spawn_in(3);
        step();
        hit = 1'b0;
        check_eq("spawn_hit_ignored", 32'(score), 32'd2);

        // Three consecutive timeouts end the game
        expect_expire_in(8, 1);
        expect_spawn_in(4);
        expect_expire_in(9, 2);
        expect_spawn_in(4);
        expect_expire_in(9, 3);
        check_eq("over_flag", 32'(game_over), 32'd1);
        check_eq("over_busy", 32'(busy), 32'd0);
        check_eq("over_score", 32'(score), 32'd2);
        hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("over_no_spawn", 32'(poner_topo), 32'd0);
        end
        hit = 1'b0;
        check_eq("over_score_frozen", 32'(score), 32'd2);
        check_eq("over_misses_frozen", 32'(misses), 32'd3);

        // Restart from OVER, then window shrink 8 -> 6 -> 4 -> 4
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_over", 32'(game_over), 32'd0);
        check_eq("restart_score", 32'(score), 32'd0);
        check_eq("restart_misses", 32'(misses), 32'd0);
        expect_spawn_in(4);
        hit_stage(0, 6, 1);
        expect_spawn_in(4);
        hit_stage(8, 4, 2);
        expect_spawn_in(4);
        hit_stage(16, 4, 3);
        check_eq("shrink_over", 32'(game_over), 32'd1);
        check_eq("shrink_score", 32'(score), 32'd24);

        // Reset in the middle of a WAIT window
        start = 1'b1;
        step();
        start = 1'b0;
        expect_spawn_in(4);
        hit_after(1, 1);
        expect_spawn_in(4);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_last = 4'd0;
        check_eq("midrst_poner", 32'(poner_topo), 32'd0);
        check_eq("midrst_score", 32'(score), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_over", 32'(game_over), 32'd0);
        check_eq("midrst_misses", 32'(misses), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("midrst_idle", 32'(poner_topo | busy), 32'd0);
        end

        // Long run: model-checked cells, no back-to-back repeats, full coverage, saturation
        start = 1'b1;
        step();
        start = 1'b0;
        expect_spawn_in(4);
        seen = 16'h0;
        seen[n_celda_poner_topo] = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            hit_after(1, (i > 255) ? 255 : i);
            prev = n_celda_poner_topo;
            expect_spawn_in(4);
            check_eq("no_repeat", 32'(n_celda_poner_topo != prev), 32'd1);
            seen[n_celda_poner_topo] = 1'b1;
        end
        check_eq("all_cells", 32'(seen), 32'h0000FFFF);
        check_eq("score_saturated", 32'(score), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/topo_spawner.md
Name: topo_spawner

Overview:
- Game controller that drives the mole board's placement interface and consumes its hit result.
- Picks pseudo-random cells from a 16-bit LFSR and issues one-cycle place pulses (cell number + strobe) to the 4x4 mole board.
- Opens a timed hit window per mole; scores hits, counts misses, ends the game after MAX_MISSES and shortens the window as score rises.
- Sits between the top-level game FSM/VGA score display and the mole board.

Parameters:
- SEED, 16'hACE1, LFSR reset value; a value of 0 is loaded as 16'h0001.
- WINDOW_CYCLES, 50_000_000, initial hit window length in clk cycles (≥2).
- WINDOW_MIN, 12_500_000, floor for the shrinking window (≥2, ≤WINDOW_CYCLES).
- WINDOW_STEP, 6_250_000, window decrement applied every 8 hits.
- GAP_CYCLES, 25_000_000, idle cycles between moles (≥1).
- MAX_MISSES, 3, misses that end the game (1..15).
- SCORE_W, 8, score counter width.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, level; sampled in IDLE/OVER to begin a game.
- hit, input, 1, board hit indication; qualified only in WAIT.
- n_celda_poner_topo, output, 4, cell to place mole; registered.
- poner_topo, output, 1, one-cycle place strobe.
- topo_expire, output, 1, one-cycle pulse on timeout; n_celda_poner_topo still holds the expired cell.
- score, output, SCORE_W, hits this game; saturating.
- misses, output, 4, timeouts this game.
- busy, output, 1, high in GAP/SPAWN/WAIT.
- game_over, output, 1, high in OVER.

Behaviour:
- Reset (sync, active-high): state=IDLE, lfsr=SEED (or 1), all outputs 0, window_len=WINDOW_CYCLES, counters 0, last_cell=0, hits_mod8=0.
- LFSR: Galois, shift right, taps 16'hB400. Advances every non-reset cycle in every state, so start timing seeds variety.
- States: IDLE, GAP, SPAWN, WAIT, OVER.
- IDLE: start=1 → GAP next cycle. Clears score, misses, window_len, hits_mod8 on the transition.
- GAP: gap counter runs for exactly GAP_CYCLES cycles. On the last GAP cycle, the next cell is latched into n_celda_poner_topo:
  - cand=lfsr[3:0];
  - if cand==last_cell, use cand+1 (mod 16).
  - Then → SPAWN.
- SPAWN: exactly 1 cycle. poner_topo=1, last_cell updated, window counter cleared → WAIT.
- WAIT: window counter increments each cycle. n_celda_poner_topo held stable.
  - hit=1 → score+1 (saturates at all-ones); hits_mod8+1; if hits_mod8 wraps to 0, window_len = max(window_len−WINDOW_STEP, WINDOW_MIN). → GAP.
  - No hit and counter==window_len−1 → topo_expire=1 that cycle, misses+1. If new misses==MAX_MISSES → OVER, else → GAP.
  - A hit in the same cycle as the timeout condition counts as a hit; no miss is recorded.
- poner_topo-to-window-end latency: the window spans window_len WAIT cycles starting the cycle after SPAWN.
- hit outside WAIT is ignored (no score change); this includes a hit in the SPAWN cycle.
- start outside IDLE/OVER is ignored.
- OVER: game_over=1, busy=0, score/misses frozen. start=1 → GAP with the same clears as IDLE.
- Reset mid-game (any state) returns to the full reset values next edge; any strobe in flight is dropped.
- poner_topo and topo_expire never assert in the same cycle, and each is never high for 2 consecutive cycles.
- All outputs are registered; no combinational path from hit or start to any output.

Test Plan:
1. Bench params: SEED=16'hACE1, WINDOW_CYCLES=8, WINDOW_MIN=4, WINDOW_STEP=2, GAP_CYCLES=4, MAX_MISSES=3. Reset 2 cycles → all outputs 0, game_over=0, busy=0. start pulse at cycle 0 → busy=1 at cycle 1; poner_topo high for 1 cycle at cycle 5; n_celda_poner_topo equals the model-predicted LFSR cell (≠ previous cell).
2. Hit 3 cycles after the SPAWN cycle → score=1 next cycle, misses=0, no topo_expire; next poner_topo exactly 4 GAP cycles + 1 later.
3. No hit → topo_expire pulse 8 cycles after SPAWN with the same cell on n_celda_poner_topo; misses=1. Three consecutive timeouts → game_over=1, busy=0, score unchanged.
4. Hit asserted on the exact timeout cycle → score+1, misses unchanged, no topo_expire. Hits held during GAP and SPAWN → score unchanged.
5. 8 consecutive hits → window becomes 6, then 4 after 16 hits, and stays 4 after 24 hits; verify timeout pulse position each stage.
6. Reset asserted mid-WAIT → next cycle state IDLE, score=0, poner_topo=0. Start in OVER → score/misses cleared, new mole appears; model-checked over 1000 moles: no cell repeats back-to-back, all 16 cells hit.
